// File: rtl/lcg_roll_pkg.sv
// lcg_roll_pkg
// Shared types and constants for the MINSTD dice-roll generator.
//   state_e       : roll controller states
//   MINSTD_A/M    : Park-Miller multiplier and modulus (2^31-1)
//   sanitise_seed : maps an arbitrary seed onto a legal non-zero LCG state
package lcg_roll_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_ADV  = 2'd2
    } state_e;

    localparam logic [14:0] MINSTD_A = 15'd16807;
    localparam logic [30:0] MINSTD_M = 31'h7FFF_FFFF;

    // Zero is a fixed point of the LCG and values >= M are outside the
    // field, so both collapse to 1.
    function automatic logic [30:0] sanitise_seed(input longint unsigned seed);
        if (seed == 64'd0 || seed >= 64'h7FFF_FFFF) begin
            return 31'd1;
        end
        return seed[30:0];
    endfunction

endpackage

// File: rtl/lcg_minstd_step.sv
// lcg_minstd_step
// One combinational MINSTD step: o_x = 16807 * i_x mod (2^31-1).
//   i_x : current state, 1 .. 2^31-2
//   o_x : next state, never 0 for a legal input
module lcg_minstd_step
    import lcg_roll_pkg::*;
(
    input  logic [30:0] i_x,
    output logic [30:0] o_x
);

    logic [45:0] prod;
    logic [31:0] fold;

    // 2^31 == 1 (mod 2^31-1): the high part folds back onto the low part.
    // The folded sum is below 2*M, so one conditional subtract finishes it.
    always_comb begin
        prod = {15'd0, i_x} * {31'd0, MINSTD_A};
        fold = {1'b0, prod[30:0]} + {17'd0, prod[45:31]};
        if (fold >= {1'b0, MINSTD_M}) begin
            o_x = 31'(fold - {1'b0, MINSTD_M});
        end else begin
            o_x = fold[30:0];
        end
    end

endmodule

// File: rtl/lcg_roll_gen.sv
// lcg_roll_gen
// Dice-roll generator: a start pulse shows a sequence of MINSTD values that
// slows down over STAGES stages and settles on a final value, which is pushed
// into a small result history.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_start        : start / restart pulse (wins over i_stop)
//   i_stop         : settle early on the current value (ignored when idle)
//   i_hist_sel     : history index, 0 = newest
//   o_random       : displayed value
//   o_busy         : roll in progress
//   o_done         : one-cycle pulse at settle
//   o_hist         : selected history entry (0 if index out of range)
//   o_hist_cnt     : number of valid history entries, saturating
//
// state  | meaning
// S_IDLE | no roll running, o_random holds the last shown value
// S_HOLD | holding a value; hold counter counts down to zero
// S_ADV  | advance bookkeeping, folded into the S_HOLD expiry cycle
module lcg_roll_gen
    import lcg_roll_pkg::*;
#(
    parameter int unsigned     OUT_W      = 4,
    parameter int unsigned     PERIOD0    = 32'd8388608,
    parameter int unsigned     STAGES     = 4,
    parameter int unsigned     FIRST_REPS = 9,
    parameter int unsigned     HIST_DEPTH = 4,
    parameter longint unsigned SEED       = 1,
    localparam int HS_W  = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1,
    localparam int CNT_W = $clog2(HIST_DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [HS_W-1:0]  i_hist_sel,
    output logic [OUT_W-1:0] o_random,
    output logic             o_busy,
    output logic             o_done,
    output logic [OUT_W-1:0] o_hist,
    output logic [CNT_W-1:0] o_hist_cnt
);

    localparam longint unsigned PMAX   = 64'(PERIOD0) << (STAGES - 1);
    localparam int              HOLD_W = $clog2(PMAX) + 1;
    localparam int              STG_W  = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int              REP_W  = (FIRST_REPS > 1) ? $clog2(FIRST_REPS + 1) : 1;
    localparam logic [30:0]     SEED_X = sanitise_seed(SEED);

    // Down-counter load value: a value is visible for load+1 cycles.
    function automatic logic [HOLD_W-1:0] hold_load(input logic [STG_W-1:0] s);
        return HOLD_W'((64'(PERIOD0) << s) - 64'd1);
    endfunction

    function automatic logic [REP_W-1:0] reps_of(input logic [STG_W-1:0] s);
        int unsigned r;
        r = FIRST_REPS >> s;
        return (r < 1) ? REP_W'(1) : REP_W'(r);
    endfunction

    state_e             state_q, state_d;
    logic [30:0]        x_q, x_d, x_step;
    logic [OUT_W-1:0]   rnd_q, rnd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [STG_W-1:0]   stage_q, stage_d, stage_nx;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               adv, push;

    logic [OUT_W-1:0]   hist_q [HIST_DEPTH];
    logic [CNT_W-1:0]   hist_cnt_q;

    lcg_minstd_step u_step (
        .i_x (x_q),
        .o_x (x_step)
    );

    assign stage_nx = stage_q + STG_W'(1);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        rnd_d   = rnd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        stage_d = stage_q;
        rep_d   = rep_q;
        hold_d  = hold_q;
        adv     = 1'b0;
        push    = 1'b0;

        case (state_q)
            S_HOLD: begin
                if (i_stop || (hold_q == '0 && rep_q >= reps_of(stage_q)
                               && stage_q >= STG_W'(STAGES - 1))) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    push    = 1'b1;
                    state_d = S_IDLE;
                end else if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else if (rep_q < reps_of(stage_q)) begin
                    adv    = 1'b1;
                    rep_d  = rep_q + REP_W'(1);
                    hold_d = hold_load(stage_q);
                end else begin
                    adv     = 1'b1;
                    stage_d = stage_nx;
                    rep_d   = REP_W'(1);
                    hold_d  = hold_load(stage_nx);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Restart abandons whatever the roll was doing, including a settle.
        if (i_start) begin
            adv     = 1'b1;
            push    = 1'b0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            stage_d = '0;
            rep_d   = REP_W'(1);
            hold_d  = hold_load('0);
            state_d = S_HOLD;
        end

        if (adv) begin
            x_d   = x_step;
            rnd_d = x_step[OUT_W-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            x_q     <= SEED_X;
            rnd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            stage_q <= '0;
            rep_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            rnd_q   <= rnd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            stage_q <= stage_d;
            rep_q   <= rep_d;
            hold_q  <= hold_d;
        end
    end

    // Settle never advances X, so the pushed value is the one on display.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_q[i] <= '0;
            end
            hist_cnt_q <= '0;
        end else if (push) begin
            for (int i = HIST_DEPTH - 1; i > 0; i--) begin
                hist_q[i] <= hist_q[i-1];
            end
            hist_q[0] <= rnd_q;
            if (hist_cnt_q != CNT_W'(HIST_DEPTH)) begin
                hist_cnt_q <= hist_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        o_hist = '0;
        if (32'(i_hist_sel) < HIST_DEPTH) begin
            o_hist = hist_q[i_hist_sel];
        end
    end

    assign o_random   = rnd_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_hist_cnt = hist_cnt_q;

endmodule

// File: tb/tb_lcg_roll_gen.sv
module tb_lcg_roll_gen;

    localparam int PERIOD0    = 2;
    localparam int STAGES     = 4;
    localparam int FIRST_REPS = 9;
    localparam int HIST_DEPTH = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_stop = 1'b0;
    logic [1:0]  i_hist_sel = 2'd0;
    logic [3:0]  o_random, o_hist;
    logic        o_busy, o_done;
    logic [2:0]  o_hist_cnt;
    logic [30:0] step_in = 31'd1;
    logic [30:0] step_out;

    always #5 i_clk = ~i_clk;

    lcg_roll_gen #(
        .OUT_W(4), .PERIOD0(PERIOD0), .STAGES(STAGES),
        .FIRST_REPS(FIRST_REPS), .HIST_DEPTH(HIST_DEPTH), .SEED(1)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_stop(i_stop),
        .i_hist_sel(i_hist_sel), .o_random(o_random), .o_busy(o_busy),
        .o_done(o_done), .o_hist(o_hist), .o_hist_cnt(o_hist_cnt)
    );

    lcg_minstd_step u_step_ref (.i_x(step_in), .o_x(step_out));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: plain 64-bit modulo, independent of the fold trick.
    function automatic longint unsigned mstep(input longint unsigned x);
        return (x * 64'd16807) % 64'd2147483647;
    endfunction

    function automatic int reps_m(input int k);
        int r;
        r = FIRST_REPS >> k;
        return (r < 1) ? 1 : r;
    endfunction

    longint unsigned mx = 1;
    int  s_stage, s_rep, s_left;
    bit  settled;
    logic [3:0] rec [$];
    logic [3:0] finals [$];

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_start(input bit with_stop);
        i_start = 1'b1;
        i_stop  = with_stop;
        tick();
        i_start = 1'b0;
        i_stop  = 1'b0;
        mx      = mstep(mx);
        s_stage = 0;
        s_rep   = 1;
        s_left  = PERIOD0;
        settled = 1'b0;
    endtask

    task automatic follow(input int ncyc, output int ncy);
        ncy = 0;
        while (ncy < ncyc && !settled) begin
            check_val("roll_value", o_random, mx[3:0]);
            check_val("roll_busy", o_busy, 1);
            check_val("roll_no_done", o_done, 0);
            rec.push_back(o_random);
            tick();
            ncy++;
            s_left--;
            if (s_left == 0) begin
                if (s_rep < reps_m(s_stage)) begin
                    s_rep++;
                    mx = mstep(mx);
                    s_left = PERIOD0 << s_stage;
                end else if (s_stage < STAGES - 1) begin
                    s_stage++;
                    s_rep = 1;
                    mx = mstep(mx);
                    s_left = PERIOD0 << s_stage;
                end else begin
                    settled = 1'b1;
                end
            end
        end
    endtask

    task automatic expect_settle(input int cnt);
        i_hist_sel = 2'd0;
        #1;
        check_val("settle_done", o_done, 1);
        check_val("settle_busy", o_busy, 0);
        check_val("settle_value", o_random, mx[3:0]);
        check_val("settle_hist0", o_hist, mx[3:0]);
        check_val("settle_hist_cnt", o_hist_cnt, cnt);
        finals.push_back(mx[3:0]);
        tick();
        check_val("done_one_cycle", o_done, 0);
        check_val("idle_busy", o_busy, 0);
    endtask

    task automatic stop_now(input int cnt);
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        expect_settle(cnt);
    endtask

    initial begin
        int ncy;
        bit done_seen;
        logic [30:0] rx;

        // Standalone LCG step
        step_in = 31'd1;          #1; check_val("step_1", step_out, 16807);
        step_in = 31'd16807;      #1; check_val("step_16807", step_out, 282475249);
        step_in = 31'd2147483646; #1; check_val("step_max", step_out, 2147466840);
        for (int i = 0; i < 2000; i++) begin
            rx = 31'($urandom());
            if (rx == 31'h7FFF_FFFF) rx = 31'h7FFF_FFFE;
            if (rx == 31'd0) rx = 31'd1;
            step_in = rx;
            #1;
            check_val("step_rand", step_out, mstep(64'(rx)));
        end

        // Reset and idle
        repeat (3) @(posedge i_clk);
        #1;
        check_val("in_reset_random", o_random, 0);
        check_val("in_reset_busy", o_busy, 0);
        i_rst_n = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (o_done) done_seen = 1'b1;
        end
        check_val("idle_no_done", done_seen, 0);
        check_val("idle_random", o_random, 0);
        check_val("idle_busy", o_busy, 0);
        check_val("idle_hist_cnt", o_hist_cnt, 0);
        check_val("idle_hist0", o_hist, 0);

        // Full roll with hand-known first values
        rec.delete();
        do_start(1'b0);
        follow(200, ncy);
        check_val("first_val_t1", rec[0], 7);
        check_val("second_val_t3", rec[2], 1);
        check_val("third_val_t5", rec[4], 9);
        check_val("full_roll_cycles", ncy, 66);
        expect_settle(1);

        // Early stop at t+10, settle at t+11
        do_start(1'b0);
        follow(9, ncy);
        stop_now(2);
        i_hist_sel = 2'd1;
        #1;
        check_val("stop_hist1", o_hist, finals[0]);
        i_hist_sel = 2'd0;

        // Later start continues X; restart at t+20
        do_start(1'b0);
        follow(19, ncy);
        do_start(1'b0);
        check_val("restart_no_done", o_done, 0);
        check_val("restart_no_push", o_hist_cnt, 2);
        follow(200, ncy);
        check_val("restart_roll_cycles", ncy, 66);
        expect_settle(3);

        // Start and stop together: restart wins
        do_start(1'b0);
        follow(5, ncy);
        do_start(1'b1);
        check_val("startstop_no_done", o_done, 0);
        check_val("startstop_busy", o_busy, 1);
        check_val("startstop_no_push", o_hist_cnt, 3);
        follow(30, ncy);
        stop_now(4);

        // Two more rolls: history saturates
        for (int k = 0; k < 2; k++) begin
            do_start(1'b0);
            follow(3 + 4 * k, ncy);
            stop_now(4);
        end
        for (int s = 0; s < 4; s++) begin
            i_hist_sel = 2'(s);
            #1;
            check_val("hist_order", o_hist, finals[5 - s]);
        end
        i_hist_sel = 2'd0;

        // Stop while idle is ignored
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        check_val("idle_stop_no_done", o_done, 0);
        check_val("idle_stop_cnt", o_hist_cnt, 4);

        // Asynchronous reset mid-roll
        do_start(1'b0);
        follow(7, ncy);
        i_rst_n = 1'b0;
        #2;
        check_val("rst_random", o_random, 0);
        check_val("rst_busy", o_busy, 0);
        check_val("rst_done", o_done, 0);
        check_val("rst_hist_cnt", o_hist_cnt, 0);
        check_val("rst_hist0", o_hist, 0);
        i_hist_sel = 2'd3;
        #1;
        check_val("rst_hist3", o_hist, 0);
        i_hist_sel = 2'd0;
        tick();
        tick();
        i_rst_n = 1'b1;
        mx = 1;
        do_start(1'b0);
        check_val("post_rst_first", o_random, 7);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
